peripheral_msi_master_port_ahb4: RTL and testbench
==================================================

// Module: peripheral_msi_master_port_ahb4
// PURPOSE
//  Per-master front end of the AHB4 MSI interconnect; sits upstream of the SLAVES slave-port arbiters.
//  Decodes the AHB master's address to one slave port and fans the request out.
//  Holds the address phase while that slave port has not granted this master.
//  Returns the data-phase response and drives can_switch so the slave-port arbiter knows when it may re-arbitrate.
// PARAMETERS
//  PLEN    64  address width
//  XLEN    64  data width
//  SLAVES  5   number of slave ports (address windows)
// PORTS
//  HRESETn        in   1               async reset, active-low
//  HCLK           in   1               clock
//  mstHSEL/HWRITE/HMASTLOCK in 1       from AHB master
//  mstHADDR       in   PLEN            address
//  mstHWDATA      in   XLEN            write data
//  mstHSIZE/HBURST in  3               size / burst
//  mstHPROT       in   4               protection
//  mstHTRANS      in   2               transfer type
//  mstHREADY      in   1               bus HREADY
//  mstHRDATA      out  XLEN            read data
//  mstHREADYOUT   out  1               ready to master
//  mstHRESP       out  1               response to master
//  slvHADDR_base  in   SLAVES x PLEN   window base per slave
//  slvHADDR_mask  in   SLAVES x PLEN   window mask per slave
//  slvHSEL        out  SLAVES          request to slave port j
//  slvHADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK out  as mst  shared fan-out
//  slvHREADY      out  1               to slave port mstHREADY
//  slvHRDATA      in   SLAVES x XLEN   from slave ports
//  slvHREADYOUT   in   SLAVES          from slave ports
//  slvHRESP       in   SLAVES          from slave ports
//  granted        in   SLAVES          slave port j routes this master
//  can_switch     out  SLAVES          slave port j may re-arbitrate
// BEHAVIOUR
//  Reset: HRESETn is asynchronous, active-low; clock is HCLK. state=IDLE; mstHREADYOUT=1, mstHRESP=0;
//   slvHSEL=0, can_switch='1, dp_valid=0.
//  Decode: hit[j] = (HADDR & mask[j]) == (base[j] & mask[j]). Lowest j wins on overlap. Result is one-hot.
//  Active transfer: mstHSEL & HTRANS in {NONSEQ, SEQ} & mstHREADY.
//  FSM (IDLE, WAIT, ERR1, ERR2):
//   IDLE, active, no hit -> ERR1 (nothing forwarded).
//   IDLE, active, hit j, !granted[j] -> WAIT. Capture all address-phase signals and j into the hold register.
//   IDLE, active, hit j, granted[j] -> stay IDLE. Address goes straight through. dp_valid<=1, dp_slave<=j.
//   WAIT -> IDLE when granted[hold_j] & slvHREADYOUT[hold_j]. Then dp_valid<=1, dp_slave<=hold_j.
//   ERR1 -> ERR2 -> IDLE unconditionally.
//  Outputs in WAIT:
//   slv* driven from the hold register; captured SEQ is sent as NONSEQ.
//   slvHSEL[hold_j]=1; slvHREADY=slvHREADYOUT[hold_j]; mstHREADYOUT=0, mstHRESP=0.
//  Outputs in IDLE: slv* pass mst* through; slvHSEL=hit & {SLAVES{mstHSEL}}; slvHREADY=mstHREADY.
//  Data phase: when dp_valid, mstHRDATA/HREADYOUT/HRESP = slv*[dp_slave]. Otherwise mstHREADYOUT=1, mstHRESP=0.
//   dp_valid clears on mstHREADY with no new granted transfer.
//  Error response:
//   ERR1: mstHREADYOUT=0, mstHRESP=1.
//   ERR2: mstHREADYOUT=1, mstHRESP=1.
//   Master inputs are ignored during ERR1/ERR2.
//  can_switch[j] = 0 iff this master targets j and (HTRANS in {SEQ, BUSY} or HMASTLOCK), or state==WAIT on j.
//   1 for every other j.
//  Simultaneous events: a new active transfer in the same cycle a WAIT completes is not possible,
//   because mstHREADYOUT=0 in WAIT.
//  Reset mid-WAIT drops the held transfer; all outputs return to reset values.
// STRUCTURE
//  Package peripheral_msi_pkg_ahb4: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, state enum.
//  Sub-module peripheral_msi_addr_decoder_ahb4: combinational base/mask decode -> one-hot hit plus miss flag.
// TESTING
//  1. granted=5'b00001, NONSEQ read 0x0000_1000 hitting slave 0
//     -> slvHSEL=5'b00001 same cycle; next cycle HRDATA=slvHRDATA[0].
//  2. hit slave 2, granted[2]=0 for 3 cycles
//     -> HREADYOUT=0 for 3 cycles; held HADDR stable; granted on cycle 4 -> transfer completes with OKAY.
//  3. unmapped address 0xFFFF_0000 NONSEQ
//     -> HREADYOUT 0 then 1; HRESP=1 both cycles; slvHSEL stays 0.
//  4. INCR4 burst to slave 1 with HMASTLOCK=1
//     -> can_switch[1]=0 through all 4 beats, 1 after final IDLE.
//  5. SEQ beat crossing into slave 3, not granted
//     -> held beat presented as NONSEQ when granted.
//  6. HRESETn pulsed low in WAIT
//     -> state IDLE, HREADYOUT=1, slvHSEL=0 immediately.

Source files
------------

// File: rtl/peripheral_msi_pkg_ahb4.sv
// Shared AHB4 encodings, FSM state codes and the held address-phase record for the MSI master port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package peripheral_msi_pkg_ahb4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    // Address-phase control captured while a slave port has not yet granted us.
    typedef struct packed {
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic [1:0] trans;
        logic       lock;
    } ahb_ctrl_t;

    // A real transfer is presented: selected, NONSEQ/SEQ, and the bus is ready.
    function automatic logic is_active(input logic sel, input logic [1:0] trans, input logic ready);
        return sel & ready & ((trans == HTRANS_NONSEQ) | (trans == HTRANS_SEQ));
    endfunction

endpackage

// File: rtl/peripheral_msi_addr_decoder_ahb4.sv
// Base/mask address decode to a one-hot slave select; lowest index wins on overlapping windows.
// Latency: purely combinational.
// Backpressure: none.
module peripheral_msi_addr_decoder_ahb4 #(
    parameter int PLEN   = 64,
    parameter int SLAVES = 5,
    parameter int IW     = 3
) (
    input  logic [PLEN-1:0]        addr,
    input  logic [SLAVES*PLEN-1:0] base,
    input  logic [SLAVES*PLEN-1:0] mask,
    output logic [SLAVES-1:0]      hit,
    output logic [IW-1:0]          hit_idx,
    output logic                   miss
);

    // Scan from the top so the lowest matching window is the one left standing.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int j = SLAVES - 1; j >= 0; j--) begin
            if ((addr & mask[j*PLEN +: PLEN]) == (base[j*PLEN +: PLEN] & mask[j*PLEN +: PLEN])) begin
                hit     = '0;
                hit[j]  = 1'b1;
                hit_idx = IW'(j);
            end
        end
        miss = ~|hit;
    end

endmodule

// File: rtl/peripheral_msi_master_port_ahb4.sv
// Per-master AHB4 front end: decodes to one slave port, holds the address phase until granted, returns the data phase.
// Latency: granted transfers pass straight through (0 cycles); ungranted ones wait in WAIT until grant and slave ready.
// Backpressure: mstHREADYOUT low while waiting for grant, during ERR1, or while the addressed slave stalls its data phase.
module peripheral_msi_master_port_ahb4
    import peripheral_msi_pkg_ahb4::*;
#(
    parameter int PLEN   = 64,
    parameter int XLEN   = 64,
    parameter int SLAVES = 5
) (
    input  logic                   HRESETn,
    input  logic                   HCLK,

    input  logic                   mstHSEL,
    input  logic [PLEN-1:0]        mstHADDR,
    input  logic [XLEN-1:0]        mstHWDATA,
    output logic [XLEN-1:0]        mstHRDATA,
    input  logic                   mstHWRITE,
    input  logic [2:0]             mstHSIZE,
    input  logic [2:0]             mstHBURST,
    input  logic [3:0]             mstHPROT,
    input  logic [1:0]             mstHTRANS,
    input  logic                   mstHMASTLOCK,
    input  logic                   mstHREADY,
    output logic                   mstHREADYOUT,
    output logic                   mstHRESP,

    input  logic [SLAVES*PLEN-1:0] slvHADDR_base,
    input  logic [SLAVES*PLEN-1:0] slvHADDR_mask,
    output logic [SLAVES-1:0]      slvHSEL,
    output logic [PLEN-1:0]        slvHADDR,
    output logic [XLEN-1:0]        slvHWDATA,
    input  logic [SLAVES*XLEN-1:0] slvHRDATA,
    output logic                   slvHWRITE,
    output logic [2:0]             slvHSIZE,
    output logic [2:0]             slvHBURST,
    output logic [3:0]             slvHPROT,
    output logic [1:0]             slvHTRANS,
    output logic                   slvHMASTLOCK,
    output logic                   slvHREADY,
    input  logic [SLAVES-1:0]      slvHREADYOUT,
    input  logic [SLAVES-1:0]      slvHRESP,

    input  logic [SLAVES-1:0]      granted,
    output logic [SLAVES-1:0]      can_switch
);

    localparam int IW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    logic [SLAVES-1:0] hit;
    logic [IW-1:0]     hit_idx;
    logic              miss;

    logic [1:0]        state;
    logic              dp_valid;
    logic [IW-1:0]     dp_slave;
    logic [SLAVES-1:0] hold_sel;
    logic [IW-1:0]     hold_idx;
    logic [PLEN-1:0]   hold_addr;
    ahb_ctrl_t         hold_ctrl;

    logic              active;
    logic              wait_done;
    logic              keep_owner;

    peripheral_msi_addr_decoder_ahb4 #(
        .PLEN   (PLEN),
        .SLAVES (SLAVES),
        .IW     (IW)
    ) u_decoder (
        .addr    (mstHADDR),
        .base    (slvHADDR_base),
        .mask    (slvHADDR_mask),
        .hit     (hit),
        .hit_idx (hit_idx),
        .miss    (miss)
    );

    assign active     = is_active(mstHSEL, mstHTRANS, mstHREADY);
    assign wait_done  = granted[hold_idx] & slvHREADYOUT[hold_idx];
    // Mid-burst beats and locked sequences must keep the slave port's arbiter pinned to us.
    assign keep_owner = (mstHTRANS == HTRANS_SEQ) | (mstHTRANS == HTRANS_BUSY) | mstHMASTLOCK;

    // FSM, hold register and data-phase tracking.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            dp_valid  <= 1'b0;
            dp_slave  <= '0;
            hold_sel  <= '0;
            hold_idx  <= '0;
            hold_addr <= '0;
            hold_ctrl <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (active) begin
                        if (miss) begin
                            state    <= ST_ERR1;
                            dp_valid <= 1'b0;
                        end else if (granted[hit_idx]) begin
                            dp_valid <= 1'b1;
                            dp_slave <= hit_idx;
                        end else begin
                            state           <= ST_WAIT;
                            dp_valid        <= 1'b0;
                            hold_sel        <= hit;
                            hold_idx        <= hit_idx;
                            hold_addr       <= mstHADDR;
                            hold_ctrl.write <= mstHWRITE;
                            hold_ctrl.size  <= mstHSIZE;
                            hold_ctrl.burst <= mstHBURST;
                            hold_ctrl.prot  <= mstHPROT;
                            hold_ctrl.trans <= mstHTRANS;
                            hold_ctrl.lock  <= mstHMASTLOCK;
                        end
                    end else if (mstHREADY) begin
                        dp_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        state    <= ST_IDLE;
                        dp_valid <= 1'b1;
                        dp_slave <= hold_idx;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Slave-side fan-out, master-side response and arbitration hints.
    always_comb begin
        slvHSEL      = '0;
        slvHADDR     = mstHADDR;
        slvHWDATA    = mstHWDATA;
        slvHWRITE    = mstHWRITE;
        slvHSIZE     = mstHSIZE;
        slvHBURST    = mstHBURST;
        slvHPROT     = mstHPROT;
        slvHTRANS    = mstHTRANS;
        slvHMASTLOCK = mstHMASTLOCK;
        slvHREADY    = mstHREADY;
        mstHRDATA    = slvHRDATA[int'(dp_slave)*XLEN +: XLEN];
        mstHREADYOUT = 1'b1;
        mstHRESP     = HRESP_OKAY;
        can_switch   = '1;
        case (state)
            ST_IDLE: begin
                slvHSEL    = hit & {SLAVES{mstHSEL}};
                can_switch = ~(slvHSEL & {SLAVES{keep_owner}});
                if (dp_valid) begin
                    mstHREADYOUT = slvHREADYOUT[dp_slave];
                    mstHRESP     = slvHRESP[dp_slave];
                end
            end
            ST_WAIT: begin
                slvHSEL      = hold_sel;
                slvHADDR     = hold_addr;
                slvHWRITE    = hold_ctrl.write;
                slvHSIZE     = hold_ctrl.size;
                slvHBURST    = hold_ctrl.burst;
                slvHPROT     = hold_ctrl.prot;
                // The slave port sees this as the start of a fresh ownership, so a held SEQ restarts as NONSEQ.
                slvHTRANS    = (hold_ctrl.trans == HTRANS_SEQ) ? HTRANS_NONSEQ : hold_ctrl.trans;
                slvHMASTLOCK = hold_ctrl.lock;
                slvHREADY    = slvHREADYOUT[hold_idx];
                mstHREADYOUT = 1'b0;
                can_switch   = ~hold_sel;
            end
            ST_ERR1: begin
                slvHTRANS    = HTRANS_IDLE;
                mstHREADYOUT = 1'b0;
                mstHRESP     = HRESP_ERROR;
            end
            default: begin
                slvHTRANS    = HTRANS_IDLE;
                mstHRESP     = HRESP_ERROR;
            end
        endcase
        // Under reset nothing may request a slave port or pin an arbiter, whatever the master drives.
        if (!HRESETn) begin
            slvHSEL    = '0;
            can_switch = '1;
        end
    end

endmodule

// File: tb/tb_peripheral_msi_master_port_ahb4.sv
module tb_peripheral_msi_master_port_ahb4;
    import peripheral_msi_pkg_ahb4::*;

    logic          HRESETn, HCLK;
    logic          mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY;
    logic [63:0]   mstHADDR, mstHWDATA, mstHRDATA;
    logic [2:0]    mstHSIZE, mstHBURST;
    logic [3:0]    mstHPROT;
    logic [1:0]    mstHTRANS;
    logic          mstHREADYOUT, mstHRESP;
    logic [319:0]  slvHADDR_base, slvHADDR_mask, slvHRDATA;
    logic [4:0]    slvHSEL, slvHREADYOUT, slvHRESP, granted, can_switch;
    logic [63:0]   slvHADDR, slvHWDATA;
    logic          slvHWRITE, slvHMASTLOCK, slvHREADY;
    logic [2:0]    slvHSIZE, slvHBURST;
    logic [3:0]    slvHPROT;
    logic [1:0]    slvHTRANS;

    int checks = 0;
    int errors = 0;

    logic [63:0] base_cfg [5];
    logic [63:0] mask_cfg [5];

    typedef struct {
        logic [63:0] addr;
        logic        sel;
        logic [1:0]  trans;
        logic        lock;
        logic [4:0]  exp_sel;
        logic [4:0]  exp_cs;
    } vec_t;
    vec_t vecs [9];

    // Reference model state: transfer-level view (pending held beat, error countdown, data-phase owner).
    int          m_err;
    bit          m_pend;
    logic [63:0] m_addr;
    logic        m_write;
    logic [1:0]  m_trans;
    int          m_slv;
    int          m_dp;

    peripheral_msi_master_port_ahb4 #(.PLEN(64), .XLEN(64), .SLAVES(5)) dut (
        .HRESETn(HRESETn), .HCLK(HCLK),
        .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHRDATA(mstHRDATA),
        .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT),
        .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
        .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
        .slvHADDR_base(slvHADDR_base), .slvHADDR_mask(slvHADDR_mask),
        .slvHSEL(slvHSEL), .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA), .slvHRDATA(slvHRDATA),
        .slvHWRITE(slvHWRITE), .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST), .slvHPROT(slvHPROT),
        .slvHTRANS(slvHTRANS), .slvHMASTLOCK(slvHMASTLOCK), .slvHREADY(slvHREADY),
        .slvHREADYOUT(slvHREADYOUT), .slvHRESP(slvHRESP),
        .granted(granted), .can_switch(can_switch)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_master();
        mstHSEL      = 1'b0;
        mstHTRANS    = HTRANS_IDLE;
        mstHMASTLOCK = 1'b0;
        mstHREADY    = 1'b1;
        mstHWRITE    = 1'b0;
    endtask

    function automatic int ref_decode(input logic [63:0] a);
        for (int j = 0; j < 5; j++)
            if ((a & mask_cfg[j]) == (base_cfg[j] & mask_cfg[j])) return j;
        return -1;
    endfunction

    initial begin
        // Slaves 0..3: 4 KiB windows at 0x1000..0x4000; slave 4: 64 KiB window at 0 overlapping them all.
        for (int j = 0; j < 4; j++) begin
            base_cfg[j] = 64'((j + 1) * 4096);
            mask_cfg[j] = 64'hFFFF_FFFF_FFFF_F000;
        end
        base_cfg[4] = 64'h0;
        mask_cfg[4] = 64'hFFFF_FFFF_FFFF_0000;
        for (int j = 0; j < 5; j++) begin
            slvHADDR_base[j*64 +: 64] = base_cfg[j];
            slvHADDR_mask[j*64 +: 64] = mask_cfg[j];
        end

        vecs[0] = '{64'h1000,      1'b1, HTRANS_NONSEQ, 1'b0, 5'b00001, 5'b11111};
        vecs[1] = '{64'h1FF8,      1'b1, HTRANS_SEQ,    1'b0, 5'b00001, 5'b11110};
        vecs[2] = '{64'h2ABC,      1'b1, HTRANS_BUSY,   1'b0, 5'b00010, 5'b11101};
        vecs[3] = '{64'h0800,      1'b1, HTRANS_IDLE,   1'b1, 5'b10000, 5'b01111};
        vecs[4] = '{64'h3000,      1'b0, HTRANS_SEQ,    1'b1, 5'b00000, 5'b11111};
        vecs[5] = '{64'hFFFF_0000, 1'b1, HTRANS_SEQ,    1'b1, 5'b00000, 5'b11111};
        vecs[6] = '{64'h4FF0,      1'b1, HTRANS_NONSEQ, 1'b1, 5'b01000, 5'b10111};
        vecs[7] = '{64'h5000,      1'b1, HTRANS_SEQ,    1'b0, 5'b10000, 5'b01111};
        vecs[8] = '{64'h3008,      1'b1, HTRANS_IDLE,   1'b0, 5'b00100, 5'b11111};

        idle_master();
        mstHADDR = '0; mstHWDATA = '0; mstHSIZE = 3'd3; mstHBURST = 3'd0; mstHPROT = 4'h3;
        granted = '0; slvHREADYOUT = '1; slvHRESP = '0; slvHRDATA = '0;
        HRESETn = 1'b0;
        #2;
        chk("rst_hreadyout", mstHREADYOUT, 1);
        chk("rst_hresp", mstHRESP, 0);
        chk("rst_slvhsel", slvHSEL, 0);
        chk("rst_can_switch", can_switch, 5'b11111);
        tick(); tick();
        HRESETn = 1'b1;

        // Decode / pass-through / can_switch table; HREADY low so no state changes.
        mstHREADY = 1'b0;
        foreach (vecs[i]) begin
            mstHADDR = vecs[i].addr; mstHSEL = vecs[i].sel;
            mstHTRANS = vecs[i].trans; mstHMASTLOCK = vecs[i].lock;
            #1;
            chk("tbl_slvhsel", slvHSEL, vecs[i].exp_sel);
            chk("tbl_can_switch", can_switch, vecs[i].exp_cs);
            chk("tbl_slvhaddr", slvHADDR, vecs[i].addr);
            chk("tbl_slvhtrans", slvHTRANS, vecs[i].trans);
        end
        idle_master();
        tick();

        // 1: granted read of slave 0.
        granted = 5'b00001; slvHRDATA[0 +: 64] = 64'hA5A5_0000_1111_2222;
        mstHSEL = 1'b1; mstHTRANS = HTRANS_NONSEQ; mstHADDR = 64'h1000;
        #1;
        chk("t1_slvhsel", slvHSEL, 5'b00001);
        tick();
        idle_master();
        #1;
        chk("t1_hrdata", mstHRDATA, 64'hA5A5_0000_1111_2222);
        chk("t1_hreadyout", mstHREADYOUT, 1);
        chk("t1_hresp", mstHRESP, 0);
        tick();

        // 2: slave 2 not granted for 3 cycles, then granted.
        granted = 5'b00000;
        mstHSEL = 1'b1; mstHTRANS = HTRANS_NONSEQ; mstHADDR = 64'h3010; mstHWRITE = 1'b1;
        #1;
        chk("t2_slvhsel_idle", slvHSEL, 5'b00100);
        tick();
        mstHADDR = 64'hDEAD_0000; mstHTRANS = HTRANS_IDLE; mstHWRITE = 1'b0; mstHREADY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t2_hreadyout_wait", mstHREADYOUT, 0);
            chk("t2_held_haddr", slvHADDR, 64'h3010);
            chk("t2_held_hwrite", slvHWRITE, 1);
            chk("t2_held_hsel", slvHSEL, 5'b00100);
            chk("t2_can_switch", can_switch, 5'b11011);
            tick();
        end
        granted = 5'b00100;
        #1;
        chk("t2_hreadyout_grant_cycle", mstHREADYOUT, 0);
        chk("t2_slvhready", slvHREADY, 1);
        tick();
        idle_master();
        #1;
        chk("t2_hreadyout_done", mstHREADYOUT, 1);
        chk("t2_hresp_okay", mstHRESP, 0);
        tick();

        // 3: unmapped address -> two-cycle ERROR; master activity in ERR is ignored.
        granted = 5'b00001;
        mstHSEL = 1'b1; mstHTRANS = HTRANS_NONSEQ; mstHADDR = 64'hFFFF_0000;
        #1;
        chk("t3_slvhsel_miss", slvHSEL, 0);
        tick();
        mstHADDR = 64'h1000; mstHREADY = 1'b0;
        #1;
        chk("t3_err1_hreadyout", mstHREADYOUT, 0);
        chk("t3_err1_hresp", mstHRESP, 1);
        chk("t3_err1_slvhsel", slvHSEL, 0);
        tick();
        mstHREADY = 1'b1;
        #1;
        chk("t3_err2_hreadyout", mstHREADYOUT, 1);
        chk("t3_err2_hresp", mstHRESP, 1);
        chk("t3_err2_slvhsel", slvHSEL, 0);
        tick();
        idle_master();
        #1;
        chk("t3_after_hresp", mstHRESP, 0);
        chk("t3_after_hreadyout", mstHREADYOUT, 1);
        tick();

        // 4: locked INCR4 burst to slave 1.
        granted = 5'b00010;
        mstHSEL = 1'b1; mstHMASTLOCK = 1'b1; mstHBURST = 3'b011;
        for (int b = 0; b < 4; b++) begin
            mstHADDR  = 64'(64'h2000 + b * 8);
            mstHTRANS = (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            #1;
            chk("t4_can_switch1_beat", can_switch[1], 0);
            chk("t4_slvhsel_beat", slvHSEL, 5'b00010);
            tick();
        end
        idle_master();
        #1;
        chk("t4_can_switch1_after", can_switch[1], 1);
        tick();

        // 5: SEQ beat crossing from slave 2 into ungranted slave 3.
        granted = 5'b00100; slvHRDATA[3*64 +: 64] = 64'h3333_CAFE_0000_0003;
        mstHSEL = 1'b1; mstHTRANS = HTRANS_NONSEQ; mstHADDR = 64'h3FF8;
        tick();
        mstHTRANS = HTRANS_SEQ; mstHADDR = 64'h4000;
        #1;
        chk("t5_slvhsel_cross", slvHSEL, 5'b01000);
        tick();
        mstHREADY = 1'b0;
        #1;
        chk("t5_held_htrans", slvHTRANS, HTRANS_NONSEQ);
        chk("t5_held_hsel", slvHSEL, 5'b01000);
        chk("t5_held_haddr", slvHADDR, 64'h4000);
        chk("t5_can_switch", can_switch, 5'b10111);
        granted = 5'b01000;
        #1;
        chk("t5_htrans_granted", slvHTRANS, HTRANS_NONSEQ);
        tick();
        idle_master();
        #1;
        chk("t5_hreadyout_done", mstHREADYOUT, 1);
        chk("t5_hrdata", mstHRDATA, 64'h3333_CAFE_0000_0003);
        tick();

        // 6: reset asserted while waiting for a grant.
        granted = 5'b00000;
        mstHSEL = 1'b1; mstHTRANS = HTRANS_NONSEQ; mstHADDR = 64'h3000;
        tick();
        mstHREADY = 1'b0; mstHMASTLOCK = 1'b1;
        #1;
        chk("t6_hreadyout_wait", mstHREADYOUT, 0);
        HRESETn = 1'b0;
        #1;
        chk("t6_rst_hreadyout", mstHREADYOUT, 1);
        chk("t6_rst_slvhsel", slvHSEL, 0);
        chk("t6_rst_can_switch", can_switch, 5'b11111);
        chk("t6_rst_hresp", mstHRESP, 0);
        idle_master();
        tick();
        HRESETn = 1'b1;
        tick();

        // Randomized run against the transfer-level model.
        m_err = 0; m_pend = 1'b0; m_dp = -1; m_slv = 0; m_addr = '0; m_write = 1'b0; m_trans = HTRANS_IDLE;
        for (int i = 0; i < 3000; i++) begin
            int          k, d;
            logic [4:0]  e_sel, e_cs;
            logic        e_rdy, e_resp, e_sready;
            logic [63:0] e_addr;
            logic [1:0]  e_trans;
            logic        e_write;
            bit          act;

            mstHSEL      = ($urandom_range(0, 3) != 0);
            mstHTRANS    = 2'($urandom_range(0, 3));
            k            = int'($urandom_range(0, 6));
            mstHADDR     = (k < 6) ? 64'(k * 4096 + int'($urandom_range(0, 511)) * 8) : {$urandom, $urandom};
            mstHWRITE    = 1'($urandom);
            mstHMASTLOCK = ($urandom_range(0, 3) == 0);
            mstHSIZE     = 3'($urandom);
            mstHBURST    = 3'($urandom);
            mstHPROT     = 4'($urandom);
            mstHWDATA    = {$urandom, $urandom};
            granted      = 5'($urandom);
            slvHREADYOUT = 5'($urandom | $urandom);
            slvHRESP     = 5'($urandom & $urandom & $urandom);
            for (int w = 0; w < 10; w++) slvHRDATA[w*32 +: 32] = $urandom;

            d = ref_decode(mstHADDR);
            e_sel = '0; e_cs = '1; e_rdy = 1'b1; e_resp = 1'b0;
            e_addr = mstHADDR; e_trans = mstHTRANS; e_write = mstHWRITE; e_sready = 1'b0;
            if (m_err == 1) begin
                e_rdy = 1'b0; e_resp = 1'b1;
            end else if (m_err == 2) begin
                e_resp = 1'b1;
            end else if (m_pend) begin
                e_rdy = 1'b0;
                e_sel[m_slv] = 1'b1; e_cs[m_slv] = 1'b0;
                e_addr = m_addr; e_write = m_write;
                e_trans = (m_trans == HTRANS_SEQ) ? HTRANS_NONSEQ : m_trans;
                e_sready = slvHREADYOUT[m_slv];
            end else begin
                if (mstHSEL && d >= 0) begin
                    e_sel[d] = 1'b1;
                    if (mstHTRANS == HTRANS_SEQ || mstHTRANS == HTRANS_BUSY || mstHMASTLOCK) e_cs[d] = 1'b0;
                end
                if (m_dp >= 0) begin
                    e_rdy = slvHREADYOUT[m_dp]; e_resp = slvHRESP[m_dp];
                end
                e_sready = e_rdy;
            end
            // Bus HREADY follows the response this port is expected to give.
            mstHREADY = e_rdy;
            #1;
            chk("rnd_slvhsel", slvHSEL, e_sel);
            chk("rnd_can_switch", can_switch, e_cs);
            chk("rnd_hreadyout", mstHREADYOUT, e_rdy);
            chk("rnd_hresp", mstHRESP, e_resp);
            if (m_err == 0) begin
                chk("rnd_slvhaddr", slvHADDR, e_addr);
                chk("rnd_slvhtrans", slvHTRANS, e_trans);
                chk("rnd_slvhwrite", slvHWRITE, e_write);
                chk("rnd_slvhready", slvHREADY, e_sready);
                if (!m_pend && m_dp >= 0)
                    chk("rnd_hrdata", mstHRDATA, slvHRDATA[m_dp*64 +: 64]);
            end

            act = mstHSEL && (mstHTRANS == HTRANS_NONSEQ || mstHTRANS == HTRANS_SEQ) && mstHREADY;
            if (m_err == 1) begin
                m_err = 2;
            end else if (m_err == 2) begin
                m_err = 0;
            end else if (m_pend) begin
                if (granted[m_slv] && slvHREADYOUT[m_slv]) begin
                    m_pend = 1'b0; m_dp = m_slv;
                end
            end else if (act) begin
                if (d < 0) begin
                    m_err = 1; m_dp = -1;
                end else if (granted[d]) begin
                    m_dp = d;
                end else begin
                    m_pend = 1'b1; m_slv = d; m_dp = -1;
                    m_addr = mstHADDR; m_write = mstHWRITE; m_trans = mstHTRANS;
                end
            end else if (mstHREADY) begin
                m_dp = -1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
